mult_share_arbiter: RTL and testbench

Round-robin scheduler that shares one pipelined 16x16 signed multiplier (mult_gen_0, fixed latency) between NUM_REQ requesters in the mini Davinci datapath. It accepts operand pairs through valid/ready handshakes, issues at most one product per cycle, and tracks each issued operation through a tag pipeline matched to the multiplier latency. It steers every product back to the requester that issued it.

---
 rtl/mult_share_arbiter_pkg.sv | 25 ++
 rtl/mult_share_arbiter_if.sv | 29 ++
 rtl/mult_share_arbiter_rr_arbiter.sv | 48 ++++
 rtl/mult_share_arbiter.sv | 105 ++++++++++
 tb/tb_mult_share_arbiter.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_share_arbiter_pkg.sv
// Shared definitions for the mini Davinci datapath: default widths, a constant
// clog2 helper and the tag record that follows each multiplier operation.
package mini_davinci_pkg;

  localparam int unsigned MD_DATA_WID = 16;
  localparam int unsigned MD_MULT_LAT = 3;
  localparam int unsigned MD_MAX_REQ  = 8;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < value) r++;
    return r;
  endfunction

  // Tag id is sized for the largest supported requester count so one type
  // serves every instance of the scheduler.
  localparam int unsigned ID_W = clog2(MD_MAX_REQ);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } mult_tag_t;

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Requester/multiplier bundle of the shared multiplier scheduler.
// slave: scheduler side, master: requesters plus multiplier IP side.
interface mult_share_arbiter_if #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DATA_WID = mini_davinci_pkg::MD_DATA_WID
);

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*DATA_WID-1:0] req_a;
  logic [NUM_REQ*DATA_WID-1:0] req_b;
  logic [DATA_WID-1:0]         mul_a;
  logic [DATA_WID-1:0]         mul_b;
  logic [2*DATA_WID-1:0]       mul_p;
  logic [NUM_REQ-1:0]          res_valid;
  logic [2*DATA_WID-1:0]       res_data;
  logic                        busy;

  modport slave (
    input  req_valid, req_a, req_b, mul_p,
    output req_ready, mul_a, mul_b, res_valid, res_data, busy
  );

  modport master (
    output req_valid, req_a, req_b, mul_p,
    input  req_ready, mul_a, mul_b, res_valid, res_data, busy
  );

endinterface

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr,
// wrapping to the lowest request when none lies at or above ptr.
module rr_arbiter
  import mini_davinci_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic             hi_found;
  logic             lo_found;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;
  logic [IDX_W-1:0] sel;

  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && (i >= 32'(ptr)) && !hi_found) begin
        hi_found = 1'b1;
        hi_idx   = IDX_W'(i);
      end
      if (req[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = IDX_W'(i);
      end
    end
    sel = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    grant = '0;
    for (int unsigned i = 0; i < N; i++) begin
      grant[i] = lo_found && (sel == IDX_W'(i));
    end
  end

  assign grant_idx = sel;

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one pipelined signed multiplier between NUM_REQ requesters: round-robin
// issue, a tag pipeline matched to the IP latency, and per-requester result steering.
module mult_share_arbiter
  import mini_davinci_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DATA_WID = MD_DATA_WID,
  parameter int unsigned MULT_LAT = MD_MULT_LAT
) (
  input logic                 clock,
  input logic                 rst_n,
  mult_share_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = clog2(NUM_REQ);
  localparam int unsigned CNT_W = clog2(MULT_LAT + 2);

  logic [NUM_REQ-1:0]  grant;
  logic [IDX_W-1:0]    grant_idx;
  logic                hs;

  logic [IDX_W-1:0]    ptr_q,      ptr_d;
  logic [DATA_WID-1:0] mul_a_q,    mul_a_d;
  logic [DATA_WID-1:0] mul_b_q,    mul_b_d;
  logic [CNT_W-1:0]    inflight_q, inflight_d;
  mult_tag_t           tag_q [MULT_LAT+1];
  mult_tag_t           tag_d [MULT_LAT+1];
  logic [NUM_REQ-1:0]  res_valid;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (bus.req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Grant only ever selects a valid requester, so any grant is a handshake.
  assign hs = |grant;

  always_comb begin
    ptr_d   = ptr_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    if (hs) begin
      ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        mul_a_d = bus.req_a[i*DATA_WID +: DATA_WID];
        mul_b_d = bus.req_b[i*DATA_WID +: DATA_WID];
      end
    end
  end

  always_comb begin
    tag_d[0].valid = hs;
    tag_d[0].id    = ID_W'(grant_idx);
    for (int unsigned s = 1; s <= MULT_LAT; s++) begin
      tag_d[s] = tag_q[s-1];
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({hs, tag_q[MULT_LAT].valid})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      inflight_q <= '0;
      tag_q      <= '{default: '0};
    end else begin
      ptr_q      <= ptr_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
    end
  end

  always_comb begin
    res_valid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      res_valid[i] = tag_q[MULT_LAT].valid && (tag_q[MULT_LAT].id == ID_W'(i));
    end
  end

  assign bus.req_ready = grant;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = bus.mul_p;
  assign bus.busy      = (inflight_q != '0);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a 3-cycle signed multiplier model.
module tb_mult_share_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned ML = 3;

  localparam logic [63:0] A0 = 64'h0100_0005_FFFD_FFFF;
  localparam logic [63:0] B0 = 64'h0100_FFFE_FFFA_FFF9;

  logic clock = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  mult_share_arbiter_if #(.NUM_REQ(NR), .DATA_WID(DW)) bus ();

  mult_share_arbiter #(
    .NUM_REQ  (NR),
    .DATA_WID (DW),
    .MULT_LAT (ML)
  ) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Multiplier IP stand-in: product visible MULT_LAT edges after the issue edge.
  logic signed [2*DW-1:0] p1, p2;
  always @(posedge clock) begin
    p1 <= $signed(bus.mul_a) * $signed(bus.mul_b);
    p2 <= p1;
    bus.mul_p <= p2;
  end

  typedef struct {
    logic        do_rst;
    logic [3:0]  v;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  rdy;
    logic [3:0]  rv;
    logic [31:0] rd;
    logic        bz;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [3:0] v, logic [63:0] a, logic [63:0] b,
                              logic [3:0] rdy, logic [3:0] rv, logic [31:0] rd, logic bz);
    vec_t t;
    t.do_rst = r; t.v = v; t.a = a; t.b = b;
    t.rdy = rdy; t.rv = rv; t.rd = rd; t.bz = bz;
    return t;
  endfunction

  function automatic logic [63:0] sa(logic [15:0] k);
    return {16'h0100, k, 16'hFFFD, 16'hFFFF};
  endfunction

  function automatic logic [63:0] sb(logic [15:0] k);
    return {16'h0100, k, 16'hFFFA, 16'hFFF9};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    @(negedge clock);
    rst_n = 1'b1;
  endtask

  task automatic pulse(input int r, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] exp_rdy);
    bus.req_valid = '0;
    bus.req_valid[r] = 1'b1;
    bus.req_a[r*16 +: 16] = a;
    bus.req_b[r*16 +: 16] = b;
    #1;
    chk("pulse ready", 32'(bus.req_ready), 32'(exp_rdy));
    @(negedge clock);
    bus.req_valid = '0;
    bus.req_a = '1;
    bus.req_b = '1;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;

    // Contention, then fairness/wrap, then streaming on requester 2.
    tbl.push_back(mk(1, 4'b1111, A0, B0, 4'b0001, 4'b0000, 32'h0, 0));
    tbl.push_back(mk(0, 4'b1110, A0, B0, 4'b0010, 4'b0000, 32'h0, 1));
    tbl.push_back(mk(0, 4'b1100, A0, B0, 4'b0100, 4'b0000, 32'h0, 1));
    tbl.push_back(mk(0, 4'b1000, A0, B0, 4'b1000, 4'b0000, 32'h0, 1));
    tbl.push_back(mk(0, 4'b0000, A0, B0, 4'b0000, 4'b0001, 32'h0000_0007, 1));
    tbl.push_back(mk(0, 4'b0000, A0, B0, 4'b0000, 4'b0010, 32'h0000_0012, 1));
    tbl.push_back(mk(0, 4'b0000, A0, B0, 4'b0000, 4'b0100, 32'hFFFF_FFF6, 1));
    tbl.push_back(mk(0, 4'b0000, A0, B0, 4'b0000, 4'b1000, 32'h0001_0000, 1));
    tbl.push_back(mk(0, 4'b0000, A0, B0, 4'b0000, 4'b0000, 32'h0, 0));
    tbl.push_back(mk(0, 4'b1010, A0, B0, 4'b0010, 4'b0000, 32'h0, 0));
    tbl.push_back(mk(0, 4'b1010, A0, B0, 4'b1000, 4'b0000, 32'h0, 1));
    tbl.push_back(mk(0, 4'b1010, A0, B0, 4'b0010, 4'b0000, 32'h0, 1));
    tbl.push_back(mk(0, 4'b1010, A0, B0, 4'b1000, 4'b0000, 32'h0, 1));
    tbl.push_back(mk(0, 4'b1010, A0, B0, 4'b0010, 4'b0010, 32'h0000_0012, 1));
    tbl.push_back(mk(0, 4'b1010, A0, B0, 4'b1000, 4'b1000, 32'h0001_0000, 1));
    tbl.push_back(mk(0, 4'b1010, A0, B0, 4'b0010, 4'b0010, 32'h0000_0012, 1));
    tbl.push_back(mk(0, 4'b1010, A0, B0, 4'b1000, 4'b1000, 32'h0001_0000, 1));
    tbl.push_back(mk(0, 4'b0000, A0, B0, 4'b0000, 4'b0010, 32'h0000_0012, 1));
    tbl.push_back(mk(0, 4'b0000, A0, B0, 4'b0000, 4'b1000, 32'h0001_0000, 1));
    tbl.push_back(mk(0, 4'b0000, A0, B0, 4'b0000, 4'b0010, 32'h0000_0012, 1));
    tbl.push_back(mk(0, 4'b0000, A0, B0, 4'b0000, 4'b1000, 32'h0001_0000, 1));
    tbl.push_back(mk(0, 4'b0000, A0, B0, 4'b0000, 4'b0000, 32'h0, 0));
    tbl.push_back(mk(0, 4'b0100, sa(1), sb(1), 4'b0100, 4'b0000, 32'h0, 0));
    tbl.push_back(mk(0, 4'b0100, sa(2), sb(2), 4'b0100, 4'b0000, 32'h0, 1));
    tbl.push_back(mk(0, 4'b0100, sa(3), sb(3), 4'b0100, 4'b0000, 32'h0, 1));
    tbl.push_back(mk(0, 4'b0100, sa(4), sb(4), 4'b0100, 4'b0000, 32'h0, 1));
    tbl.push_back(mk(0, 4'b0100, sa(5), sb(5), 4'b0100, 4'b0100, 32'd1, 1));
    tbl.push_back(mk(0, 4'b0100, sa(6), sb(6), 4'b0100, 4'b0100, 32'd4, 1));
    tbl.push_back(mk(0, 4'b0000, sa(6), sb(6), 4'b0000, 4'b0100, 32'd9, 1));
    tbl.push_back(mk(0, 4'b0000, sa(6), sb(6), 4'b0000, 4'b0100, 32'd16, 1));
    tbl.push_back(mk(0, 4'b0000, sa(6), sb(6), 4'b0000, 4'b0100, 32'd25, 1));
    tbl.push_back(mk(0, 4'b0000, sa(6), sb(6), 4'b0000, 4'b0100, 32'd36, 1));
    tbl.push_back(mk(0, 4'b0000, sa(6), sb(6), 4'b0000, 4'b0000, 32'h0, 0));

    // Reset state, with valids applied so the ptr=0 arbitration is visible.
    #2 rst_n = 1'b0;
    bus.req_valid = 4'b0110;
    @(negedge clock);
    #1;
    chk("rst ready", 32'(bus.req_ready), 32'h2);
    chk("rst res_valid", 32'(bus.res_valid), 32'h0);
    chk("rst busy", 32'(bus.busy), 32'h0);
    chk("rst mul_a", 32'(bus.mul_a), 32'h0);
    chk("rst mul_b", 32'(bus.mul_b), 32'h0);
    @(negedge clock);
    bus.req_valid = '0;
    rst_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].do_rst) do_reset();
      bus.req_valid = tbl[i].v;
      bus.req_a = tbl[i].a;
      bus.req_b = tbl[i].b;
      #1;
      chk($sformatf("tbl%0d ready", i), 32'(bus.req_ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d res_valid", i), 32'(bus.res_valid), 32'(tbl[i].rv));
      chk($sformatf("tbl%0d busy", i), 32'(bus.busy), 32'(tbl[i].bz));
      if (tbl[i].rv != 4'b0000)
        chk($sformatf("tbl%0d res_data", i), bus.res_data, tbl[i].rd);
      @(negedge clock);
    end

    // Single op: result exactly four cycles after accept, busy for those four.
    do_reset();
    pulse(0, 16'hFFFF, 16'hFFF9, 4'b0001);
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk($sformatf("single c%0d res_valid", c), 32'(bus.res_valid), (c == 4) ? 32'h1 : 32'h0);
      chk($sformatf("single c%0d busy", c), 32'(bus.busy), (c <= 4) ? 32'h1 : 32'h0);
      if (c == 4) chk("single res_data", bus.res_data, 32'h0000_0007);
      @(negedge clock);
    end

    // Idle gaps: operands hold while junk sits on the request bus.
    do_reset();
    pulse(1, 16'h0003, 16'h0004, 4'b0010);
    for (int c = 1; c <= 2; c++) begin
      #1;
      chk("gap mul_a", 32'(bus.mul_a), 32'h0003);
      chk("gap mul_b", 32'(bus.mul_b), 32'h0004);
      chk("gap res_valid", 32'(bus.res_valid), 32'h0);
      chk("gap busy", 32'(bus.busy), 32'h1);
      @(negedge clock);
    end
    pulse(1, 16'hFFFE, 16'h0007, 4'b0010);
    for (int c = 4; c <= 9; c++) begin
      #1;
      chk($sformatf("gap c%0d mul_a", c), 32'(bus.mul_a), 32'h0000_FFFE);
      chk($sformatf("gap c%0d mul_b", c), 32'(bus.mul_b), 32'h0007);
      chk($sformatf("gap c%0d res_valid", c), 32'(bus.res_valid),
          (c == 4 || c == 7) ? 32'h2 : 32'h0);
      chk($sformatf("gap c%0d busy", c), 32'(bus.busy), (c <= 7) ? 32'h1 : 32'h0);
      if (c == 4) chk("gap res_data 1", bus.res_data, 32'h0000_000C);
      if (c == 7) chk("gap res_data 2", bus.res_data, 32'hFFFF_FFF2);
      @(negedge clock);
    end

    // Reset with three ops in flight: nothing may come back.
    do_reset();
    bus.req_a = {16'h0, 16'h0009, 16'h0008, 16'h0007};
    bus.req_b = {16'h0, 16'h0002, 16'h0002, 16'h0002};
    bus.req_valid = 4'b0111;
    #1 chk("mid ready0", 32'(bus.req_ready), 32'h1);
    @(negedge clock);
    bus.req_valid = 4'b0110;
    #1 chk("mid ready1", 32'(bus.req_ready), 32'h2);
    @(negedge clock);
    bus.req_valid = 4'b0100;
    #1 chk("mid ready2", 32'(bus.req_ready), 32'h4);
    @(negedge clock);
    bus.req_valid = '0;
    #1 chk("mid busy before rst", 32'(bus.busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid async busy", 32'(bus.busy), 32'h0);
    chk("mid async mul_a", 32'(bus.mul_a), 32'h0);
    @(negedge clock);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("mid c%0d res_valid", c), 32'(bus.res_valid), 32'h0);
      chk($sformatf("mid c%0d busy", c), 32'(bus.busy), 32'h0);
      chk($sformatf("mid c%0d mul_a", c), 32'(bus.mul_a), 32'h0);
      chk($sformatf("mid c%0d mul_b", c), 32'(bus.mul_b), 32'h0);
      @(negedge clock);
    end
    pulse(3, 16'hFFF0, 16'h0003, 4'b1000);
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk($sformatf("post c%0d res_valid", c), 32'(bus.res_valid), (c == 4) ? 32'h8 : 32'h0);
      if (c == 4) chk("post res_data", bus.res_data, 32'hFFFF_FFD0);
      @(negedge clock);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
